regbank_arbiter: RTL and testbench

REGBANK_ARBITER -- requirements
Module: regbank_arbiter

---
 rtl/regbank_arbiter.sv | 102 ++++++++++
 tb/tb_regbank_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter.sv
// 32-entry register bank with two round-robin-arbitrated write requesters,
// two combinational read ports and a sequential bulk-clear engine.
module regbank_arbiter #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr0_valid,
    input  logic [4:0]        wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [4:0]        wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    input  logic [4:0]        rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [4:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              last_grant
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [4:0]        clr_cnt;
    logic              rr_ptr;
    logic [DATA_W-1:0] regs [NREG];

    logic              wr_open;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              served;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Handshake: a write transfers on a rising edge where valid && ready.
    // ready depends on valid (grant), so a requester must not wait for
    // ready before raising valid, and must hold its request until accepted.
    always_comb begin
        wr_open = (state == IDLE) && !clr_start && !rst;
        grant0  = wr0_valid && (!wr1_valid || !rr_ptr);
        grant1  = wr1_valid && (!wr0_valid || rr_ptr);
        accept  = wr_open && (grant0 || grant1);
        served  = grant1;
        wr_addr = served ? wr1_addr : wr0_addr;
        wr_data = served ? wr1_data : wr0_data;
    end

    assign wr0_ready = wr_open && grant0;
    assign wr1_ready = wr_open && grant1;
    assign clr_busy  = (state == CLEAR);

    // No write bypass: reads always see the pre-edge contents.
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            state      <= IDLE;
            clr_cnt    <= 5'd0;
            rr_ptr     <= 1'b0;
            last_grant <= 1'b0;
            clr_done   <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state   <= CLEAR;
                        clr_cnt <= 5'd0;
                    end else if (accept) begin
                        regs[wr_addr] <= wr_data;
                        rr_ptr        <= ~served;
                        last_grant    <= served;
                    end
                end
                CLEAR: begin
                    regs[clr_cnt] <= '0;
                    clr_cnt       <= clr_cnt + 5'd1;
                    if (clr_cnt == 5'd31) begin
                        state    <= IDLE;
                        clr_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter: stimulus pushes expectations into
// queues, a negedge monitor pops and compares them against the DUT.
module tb_regbank_arbiter;

    localparam int DATA_W = 32;

    localparam int P_RD_A   = 0;
    localparam int P_RD_B   = 1;
    localparam int P_BUSY   = 2;
    localparam int P_DONE   = 3;
    localparam int P_LAST   = 4;
    localparam int P_RDY0   = 5;
    localparam int P_RDY1   = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr0_valid = 1'b0;
    logic [4:0]        wr0_addr = 5'd0;
    logic [DATA_W-1:0] wr0_data = '0;
    logic              wr0_ready;
    logic              wr1_valid = 1'b0;
    logic [4:0]        wr1_addr = 5'd0;
    logic [DATA_W-1:0] wr1_data = '0;
    logic              wr1_ready;
    logic [4:0]        rd_addr_a = 5'd0;
    logic [DATA_W-1:0] rd_data_a;
    logic [4:0]        rd_addr_b = 5'd0;
    logic [DATA_W-1:0] rd_data_b;
    logic              clr_start = 1'b0;
    logic              clr_busy;
    logic              clr_done;
    logic              last_grant;

    logic [DATA_W-1:0] exp_q[$];
    int                sel_q[$];
    logic [0:0]        gnt_q[$];
    logic              done_req = 1'b0;

    int checks = 0;
    int errors = 0;

    regbank_arbiter #(.DATA_W(DATA_W), .NREG(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr0_valid  (wr0_valid),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr0_ready  (wr0_ready),
        .wr1_valid  (wr1_valid),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .wr1_ready  (wr1_ready),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .last_grant (last_grant)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard monitor
    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [DATA_W-1:0] act;
        logic [DATA_W-1:0] e;
        int                s;
        logic              hs0;
        logic              hs1;
        hs0 = wr0_valid && wr0_ready;
        hs1 = wr1_valid && wr1_ready;
        if (hs0 || hs1) begin
            check("single_grant", {31'd0, hs0 && hs1}, '0);
            if (gnt_q.size() == 0) begin
                check("unexpected_grant", {31'd0, hs1}, 32'hFFFF_FFFF);
            end else begin
                e = {31'd0, gnt_q.pop_front()};
                check("grant_index", {31'd0, hs1}, e);
            end
        end
        while (sel_q.size() > 0) begin
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            case (s)
                P_RD_A:  begin act = rd_data_a;              check("rd_data_a", act, e);  end
                P_RD_B:  begin act = rd_data_b;              check("rd_data_b", act, e);  end
                P_BUSY:  begin act = {31'd0, clr_busy};      check("clr_busy", act, e);   end
                P_DONE:  begin act = {31'd0, clr_done};      check("clr_done", act, e);   end
                P_LAST:  begin act = {31'd0, last_grant};    check("last_grant", act, e); end
                P_RDY0:  begin act = {31'd0, wr0_ready};     check("wr0_ready", act, e);  end
                default: begin act = {31'd0, wr1_ready};     check("wr1_ready", act, e);  end
            endcase
        end
        if (done_req) begin
            check("grants_outstanding", gnt_q.size(), '0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input int sel, input logic [DATA_W-1:0] val);
        sel_q.push_back(sel);
        exp_q.push_back(val);
    endtask

    task automatic rd2(input logic [4:0] a, input logic [DATA_W-1:0] ea,
                       input logic [4:0] b, input logic [DATA_W-1:0] eb);
        rd_addr_a = a;
        rd_addr_b = b;
        expect_sig(P_RD_A, ea);
        expect_sig(P_RD_B, eb);
        tick();
    endtask

    task automatic write(input int n, input logic [4:0] addr, input logic [DATA_W-1:0] data);
        if (n == 0) begin
            wr0_valid = 1'b1; wr0_addr = addr; wr0_data = data;
        end else begin
            wr1_valid = 1'b1; wr1_addr = addr; wr1_data = data;
        end
        gnt_q.push_back(n[0]);
        tick();
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset: ready must stay low even with both requesters valid
        rst = 1'b1;
        wr0_valid = 1'b1;
        wr1_valid = 1'b1;
        expect_sig(P_RDY0, 0);
        expect_sig(P_RDY1, 0);
        tick();
        tick();
        rst = 1'b0;
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
        expect_sig(P_BUSY, 0);
        expect_sig(P_DONE, 0);
        expect_sig(P_LAST, 0);
        rd2(5'd0, 0, 5'd31, 0);

        // Single write, with same-cycle read seeing the old value
        wr0_valid = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD_BEEF;
        gnt_q.push_back(1'b0);
        expect_sig(P_RDY0, 1);
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd5;
        expect_sig(P_RD_A, 0);
        expect_sig(P_RD_B, 0);
        tick();
        wr0_valid = 1'b0;
        expect_sig(P_LAST, 0);
        rd2(5'd5, 32'hDEAD_BEEF, 5'd4, 0);

        // Both valid, each drops after acceptance: grants 0 then 1
        do_reset();
        wr0_valid = 1'b1; wr0_addr = 5'd1; wr0_data = 32'h11;
        wr1_valid = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h22;
        gnt_q.push_back(1'b0);
        expect_sig(P_RDY1, 0);
        tick();
        wr0_valid = 1'b0;
        gnt_q.push_back(1'b1);
        tick();
        wr1_valid = 1'b0;
        tick();
        tick();
        expect_sig(P_LAST, 1);
        rd2(5'd1, 32'h11, 5'd2, 32'h22);

        // Continuous contention on addr 7: pointer back at 0, order 0,1,0
        wr0_valid = 1'b1; wr1_valid = 1'b1;
        wr0_addr = 5'd7; wr1_addr = 5'd7;
        wr0_data = 32'hA; wr1_data = 32'hA; gnt_q.push_back(1'b0); tick();
        wr0_data = 32'hB; wr1_data = 32'hB; gnt_q.push_back(1'b1); tick();
        wr0_data = 32'hC; wr1_data = 32'hC; gnt_q.push_back(1'b0); tick();
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        expect_sig(P_LAST, 0);
        rd2(5'd7, 32'hC, 5'd0, 0);

        // Lone requester is served regardless of the pointer; addr 0 writable
        write(0, 5'd0, 32'h55);
        write(1, 5'd31, 32'h77);
        expect_sig(P_LAST, 1);
        rd2(5'd0, 32'h55, 5'd31, 32'h77);

        // Load address+1 everywhere, then bulk clear
        for (int i = 0; i < 32; i++) begin
            write(i % 2, i[4:0], DATA_W'(i + 1));
        end
        rd2(5'd31, 32'h20, 5'd0, 32'h1);
        clr_start = 1'b1;
        expect_sig(P_BUSY, 0);
        tick();
        for (int cyc = 0; cyc < 37; cyc++) begin
            clr_start = (cyc == 5);
            expect_sig(P_BUSY, (cyc < 32) ? 1 : 0);
            expect_sig(P_DONE, (cyc == 32) ? 1 : 0);
            if (cyc == 10) begin
                rd_addr_a = 5'd0;
                rd_addr_b = 5'd31;
                expect_sig(P_RD_A, 0);
                expect_sig(P_RD_B, 32'h20);
                wr0_valid = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hFF;
                expect_sig(P_RDY0, 0);
            end else if (cyc == 11) begin
                wr0_valid = 1'b0;
                rd_addr_a = 5'd10;
                rd_addr_b = 5'd11;
                expect_sig(P_RD_A, 0);
                expect_sig(P_RD_B, 32'hC);
            end
            tick();
        end
        clr_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd2(i[4:0], 0, 5'(i + 16), 0);
        end

        // clr_start and a write together: write waits for the clr_done cycle
        clr_start = 1'b1;
        wr0_valid = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h99;
        expect_sig(P_RDY0, 0);
        gnt_q.push_back(1'b0);
        tick();
        clr_start = 1'b0;
        for (int cyc = 0; cyc <= 32; cyc++) begin
            expect_sig(P_RDY0, (cyc == 32) ? 1 : 0);
            expect_sig(P_DONE, (cyc == 32) ? 1 : 0);
            tick();
        end
        wr0_valid = 1'b0;
        rd2(5'd9, 32'h99, 5'd8, 0);

        // Reset ten cycles into a clear: no clr_done, everything zero
        write(1, 5'd20, 32'h1234);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            expect_sig(P_BUSY, 1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            expect_sig(P_BUSY, 0);
            expect_sig(P_DONE, 0);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            rd2(i[4:0], 0, 5'(i + 16), 0);
        end

        done_req = 1'b1;
        tick();
        tick();
        $display("FAIL end_of_test: monitor did not terminate, got 0, expected 1");
        $fatal(1);
    end

endmodule
